// File: rtl/spi_slv_pkg.sv
// Shared types and constants for the SPI Mode-0 responder (spi_slave_ctrl).
`timescale 1ns/1ps
package spi_slv_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        WR_DATA = 3'd2,
        RD_WAIT = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } spi_slv_state_e;

    localparam int         CMD_BITS  = 16;
    localparam int         RW_BIT    = 7;
    localparam logic       CMD_WRITE = 1'b0;
    localparam logic       CMD_READ  = 1'b1;
    localparam logic [7:0] FIFO_ADDR = 8'h80;

    // Bit counter value seen on the last (16th) rise of a word
    localparam logic [4:0] LAST_BIT  = 5'(CMD_BITS - 1);

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    // Build a command word: address, R/W flag, pad bits cleared
    function automatic logic [15:0] make_cmd(input logic [7:0] addr, input logic rw);
        return {addr, rw, 7'd0};
    endfunction

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Register back-end request bus between spi_slave_ctrl (master) and the
// register file / FIFO (slave).
`timescale 1ns/1ps
interface spi_slave_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) ();
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output wr_en, rd_en, req_addr, wr_data,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, rd_en, req_addr, wr_data,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/spi_slv_sync.sv
// N-stage synchronizer for an asynchronous pin, plus rise/fall detection
// taken from the last stage against one further delayed copy.
`timescale 1ns/1ps
module spi_slv_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_r;
    logic              dly_r;

    // Shift the raw pin through the chain and keep a delayed copy for edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            dly_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
            dly_r  <= sync_r[STAGES-1];
        end
    end

    assign level = sync_r[STAGES-1];
    assign rise  = sync_r[STAGES-1] & ~dly_r;
    assign fall  = ~sync_r[STAGES-1] & dly_r;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI Mode-0 responder: oversamples the SPI pins in the system clock domain,
// decodes 32-bit frames (16-bit command + 16-bit data) into single-cycle
// register back-end requests, and shifts read data out on miso.
// Optional feature macro: SPI_SLV_FRAME_ERR_EN adds the frame_err abort pulse
// and an internal saturating abort counter.
`timescale 1ns/1ps
module spi_slave_ctrl
    import spi_slv_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_sclk,
    input  logic spi_ssn,
    input  logic spi_mosi,
    output logic spi_miso,
`ifdef SPI_SLV_FRAME_ERR_EN
    output logic frame_err,
`endif
    spi_slave_ctrl_if.master bus
);

    logic sclk_level_s, sclk_rise_s, sclk_fall_s;
    logic ssn_level_s, ssn_rise_s, ssn_fall_s;
    logic mosi_s;
    logic abort_s;
    logic unused_s;
    logic [DATA_W-1:0] shift_nxt_s;

    logic [SYNC_STAGES-1:0] mosi_sync_r;
    spi_slv_state_e         state_r;
    logic [DATA_W-1:0]      shift_r;
    logic [DATA_W-1:0]      tx_r;
    logic [DATA_W-1:0]      wr_data_r;
    logic [ADDR_W-1:0]      req_addr_r;
    logic [4:0]             bit_cnt_r;
    logic                   miso_r;
    logic                   wr_en_r;
    logic                   rd_en_r;

    spi_slv_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_sclk),
        .level (sclk_level_s),
        .rise  (sclk_rise_s),
        .fall  (sclk_fall_s)
    );

    spi_slv_sync #(.STAGES(SYNC_STAGES)) u_ssn_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_ssn),
        .level (ssn_level_s),
        .rise  (ssn_rise_s),
        .fall  (ssn_fall_s)
    );

    // Bring mosi into the clk domain with the same depth as sclk so the bit
    // is aligned with the detected rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_r <= '0;
        end else begin
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign shift_nxt_s = {shift_r[DATA_W-2:0], mosi_s};

    // An ssn rise only counts as an abort while a frame is still incomplete
    always_comb begin
        abort_s = 1'b0;
        case (state_r)
            CMD, WR_DATA, RD_WAIT, RD_DATA: abort_s = ssn_rise_s;
            default:                        abort_s = 1'b0;
        endcase
    end

    // Frame decoder: shifts words, issues one strobe per frame, drives miso
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            shift_r    <= '0;
            tx_r       <= '0;
            wr_data_r  <= '0;
            req_addr_r <= '0;
            bit_cnt_r  <= 5'd0;
            miso_r     <= 1'b0;
            wr_en_r    <= 1'b0;
            rd_en_r    <= 1'b0;
        end else begin
            wr_en_r <= 1'b0;
            rd_en_r <= 1'b0;
            if (abort_s) begin
                state_r <= IDLE;
                miso_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        miso_r <= 1'b0;
                        if (ssn_fall_s) begin
                            bit_cnt_r <= 5'd0;
                            shift_r   <= '0;
                            state_r   <= CMD;
                        end
                    end
                    CMD: begin
                        if (sclk_rise_s) begin
                            shift_r   <= shift_nxt_s;
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                            if (bit_cnt_r == LAST_BIT) begin
                                req_addr_r <= shift_nxt_s[DATA_W-1 -: ADDR_W];
                                bit_cnt_r  <= 5'd0;
                                if (shift_nxt_s[RW_BIT] == CMD_WRITE) begin
                                    state_r <= WR_DATA;
                                end else begin
                                    rd_en_r <= 1'b1;
                                    state_r <= RD_WAIT;
                                end
                            end
                        end
                    end
                    WR_DATA: begin
                        if (sclk_rise_s) begin
                            shift_r   <= shift_nxt_s;
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                            if (bit_cnt_r == LAST_BIT) begin
                                wr_data_r <= shift_nxt_s;
                                wr_en_r   <= 1'b1;
                                state_r   <= DONE;
                            end
                        end
                    end
                    RD_WAIT: begin
                        // A rise before the data arrives means the master has
                        // already sampled bit 15 as 0: send zeros for the rest
                        if (sclk_rise_s) begin
                            tx_r      <= '0;
                            miso_r    <= 1'b0;
                            bit_cnt_r <= 5'd1;
                            state_r   <= RD_DATA;
                        end else if (bus.rd_valid) begin
                            tx_r      <= bus.rd_data;
                            miso_r    <= bus.rd_data[DATA_W-1];
                            bit_cnt_r <= 5'd0;
                            state_r   <= RD_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (sclk_rise_s) begin
                            tx_r      <= {tx_r[DATA_W-2:0], 1'b0};
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                            if (bit_cnt_r == LAST_BIT) begin
                                miso_r  <= 1'b0;
                                state_r <= DONE;
                            end else begin
                                miso_r <= tx_r[DATA_W-2];
                            end
                        end
                    end
                    DONE: begin
                        miso_r <= 1'b0;
                        if (ssn_rise_s) begin
                            state_r <= IDLE;
                        end
                    end
                    default: begin
                        miso_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef SPI_SLV_FRAME_ERR_EN
    logic       frame_err_r;
    logic [7:0] abort_cnt_r;

    // One-cycle abort pulse plus a sticky saturating tally for debug
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_r <= 1'b0;
            abort_cnt_r <= 8'd0;
        end else begin
            frame_err_r <= abort_s;
            if (abort_s) begin
                abort_cnt_r <= sat_inc8(abort_cnt_r);
            end
        end
    end

    assign frame_err = frame_err_r;
    // Levels, the sclk fall and the debug tally have no consumer here
    assign unused_s  = ^{sclk_fall_s, sclk_level_s, ssn_level_s, abort_cnt_r};
`else
    // Levels and the sclk fall have no consumer here
    assign unused_s  = ^{sclk_fall_s, sclk_level_s, ssn_level_s};
`endif

    assign spi_miso     = miso_r;
    assign bus.wr_en    = wr_en_r;
    assign bus.rd_en    = rd_en_r;
    assign bus.req_addr = req_addr_r;
    assign bus.wr_data  = wr_data_r;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: a vector table of write/read frames
// against a register-file/FIFO back-end, plus sequences for abort,
// withheld read data and a reset during the data word.
`timescale 1ns/1ps
module tb_spi_slave_ctrl;
    import spi_slv_pkg::*;

    localparam time HALF = 50ns;
    localparam time GAP  = 200ns;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic spi_sclk = 1'b0;
    logic spi_ssn  = 1'b1;
    logic spi_mosi = 1'b0;
    logic spi_miso;
`ifdef SPI_SLV_FRAME_ERR_EN
    logic frame_err;
`endif

    spi_slave_ctrl_if bus ();

    spi_slave_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sclk  (spi_sclk),
        .spi_ssn   (spi_ssn),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
`ifdef SPI_SLV_FRAME_ERR_EN
        .frame_err (frame_err),
`endif
        .bus       (bus)
    );

    always #10 clk = ~clk;

    // Back-end stand-in: register file plus FIFO at FIFO_ADDR
    int          wr_seen = 0;
    int          rd_seen = 0;
    int          ferr_seen = 0;
    logic [7:0]  last_wr_addr = 8'h00;
    logic [7:0]  last_rd_addr = 8'h00;
    logic [15:0] last_wr_data = 16'h0000;
    logic [15:0] regfile [256];
    logic [15:0] fifo_q [$];
    int          rv_lat = 2;
    bit          rv_enable = 1'b1;
    int          rv_cnt = 0;
    logic [15:0] rv_data = 16'h0000;

    always @(negedge clk) begin
        bus.rd_valid = 1'b0;
        if (rv_cnt > 0) begin
            rv_cnt = rv_cnt - 1;
            if (rv_cnt == 0) begin
                bus.rd_valid = 1'b1;
                bus.rd_data  = rv_data;
            end
        end
        if (bus.wr_en === 1'b1) begin
            wr_seen      = wr_seen + 1;
            last_wr_addr = bus.req_addr;
            last_wr_data = bus.wr_data;
            if (bus.req_addr == FIFO_ADDR) fifo_q.push_back(bus.wr_data);
            else regfile[bus.req_addr] = bus.wr_data;
        end
        if (bus.rd_en === 1'b1) begin
            rd_seen      = rd_seen + 1;
            last_rd_addr = bus.req_addr;
            if (bus.req_addr == FIFO_ADDR) rv_data = (fifo_q.size() > 0) ? fifo_q.pop_front() : 16'h0000;
            else rv_data = regfile[bus.req_addr];
            if (rv_enable) rv_cnt = rv_lat;
        end
`ifdef SPI_SLV_FRAME_ERR_EN
        if (frame_err === 1'b1) ferr_seen = ferr_seen + 1;
`endif
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic spi_bits(input logic [15:0] tx, input int nbits, output logic [15:0] rx);
        rx = 16'h0000;
        for (int i = 15; i > 15 - nbits; i--) begin
            spi_mosi = tx[i];
            #HALF;
            spi_sclk = 1'b1;
            rx[i] = spi_miso;
            #HALF;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_begin();
        @(posedge clk);
        #3;
        spi_ssn = 1'b0;
        #HALF;
    endtask

    task automatic spi_end();
        #HALF;
        spi_ssn = 1'b1;
        #400ns;
    endtask

    task automatic spi_frame(input logic is_rd, input logic [7:0] addr,
                             input logic [15:0] data, output logic [15:0] rx);
        logic [15:0] dummy;
        spi_begin();
        spi_bits(make_cmd(addr, is_rd), 16, dummy);
        #GAP;
        spi_bits(data, 16, rx);
        spi_end();
    endtask

    typedef struct {
        logic        is_rd;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t        vecs [8];
    int          w0, r0, f0;
    logic [15:0] rx;
    logic [15:0] dummy;

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{CMD_WRITE, FIFO_ADDR, 16'h00F1, 16'h0000};
        vecs[1] = '{CMD_WRITE, FIFO_ADDR, 16'h00F2, 16'h0000};
        vecs[2] = '{CMD_WRITE, FIFO_ADDR, 16'h00F3, 16'h0000};
        vecs[3] = '{CMD_WRITE, 8'h02,     16'h2000, 16'h0000};
        vecs[4] = '{CMD_READ,  FIFO_ADDR, 16'h0000, 16'h00F1};
        vecs[5] = '{CMD_READ,  8'h02,     16'h0000, 16'h2000};
        vecs[6] = '{CMD_READ,  FIFO_ADDR, 16'h0000, 16'h00F2};
        vecs[7] = '{CMD_READ,  FIFO_ADDR, 16'h0000, 16'h00F3};

        // Reset state
        #95ns;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_miso",     32'(spi_miso),     32'h0);
        check("rst_wr_en",    32'(bus.wr_en),    32'h0);
        check("rst_rd_en",    32'(bus.rd_en),    32'h0);
        check("rst_req_addr", 32'(bus.req_addr), 32'h0);
        check("rst_wr_data",  32'(bus.wr_data),  32'h0);

        // Vector table: writes fill FIFO/regfile, reads drain them
        for (int i = 0; i < 8; i++) begin
            w0 = wr_seen; r0 = rd_seen; f0 = ferr_seen;
            spi_frame(vecs[i].is_rd, vecs[i].addr, vecs[i].data, rx);
            check("vec_ferr", 32'(ferr_seen - f0), 32'd0);
            if (vecs[i].is_rd) begin
                check("vec_rd_cnt",  32'(rd_seen - r0),  32'd1);
                check("vec_wr_none", 32'(wr_seen - w0),  32'd0);
                check("vec_rd_addr", 32'(last_rd_addr),  32'(vecs[i].addr));
                check("vec_rd_data", 32'(rx),            32'(vecs[i].exp_rd));
            end else begin
                check("vec_wr_cnt",  32'(wr_seen - w0),  32'd1);
                check("vec_rd_none", 32'(rd_seen - r0),  32'd0);
                check("vec_wr_addr", 32'(last_wr_addr),  32'(vecs[i].addr));
                check("vec_wr_data", 32'(last_wr_data),  32'(vecs[i].data));
            end
        end

        // Withheld rd_valid: zeros shifted out and the frame still completes
        rv_enable = 1'b0;
        w0 = wr_seen; r0 = rd_seen;
        spi_begin();
        spi_bits(make_cmd(8'h02, CMD_READ), 16, dummy);
        #GAP;
        spi_bits(16'h0000, 16, rx);
        #HALF;
        check("nv_state_done", 32'(dut.state_r), 32'(DONE));
        check("nv_miso_idle",  32'(spi_miso),    32'h0);
        spi_ssn = 1'b1;
        #400ns;
        rv_enable = 1'b1;
        check("nv_rd_data", 32'(rx),            32'h0000);
        check("nv_rd_cnt",  32'(rd_seen - r0),  32'd1);
        check("nv_wr_none", 32'(wr_seen - w0),  32'd0);

        // Abort after 10 command bits, then a full write frame
        w0 = wr_seen; r0 = rd_seen; f0 = ferr_seen;
        spi_begin();
        spi_bits(make_cmd(FIFO_ADDR, CMD_WRITE), 10, dummy);
        #HALF;
        spi_ssn = 1'b1;
        #400ns;
        check("ab_wr_none", 32'(wr_seen - w0), 32'd0);
        check("ab_rd_none", 32'(rd_seen - r0), 32'd0);
`ifdef SPI_SLV_FRAME_ERR_EN
        check("ab_ferr_pulse", 32'(ferr_seen - f0), 32'd1);
`endif
        w0 = wr_seen;
        spi_frame(CMD_WRITE, 8'h05, 16'hA5A5, rx);
        check("ab_next_wr_cnt",  32'(wr_seen - w0), 32'd1);
        check("ab_next_wr_addr", 32'(last_wr_addr), 32'h05);
        check("ab_next_wr_data", 32'(last_wr_data), 32'hA5A5);

        // Reset pulse in the middle of the data word
        w0 = wr_seen;
        spi_begin();
        spi_bits(make_cmd(8'h03, CMD_WRITE), 16, dummy);
        #GAP;
        spi_bits(16'h5A5A, 8, dummy);
        rst_n = 1'b0;
        #20ns;
        check("mr_miso",     32'(spi_miso),     32'h0);
        check("mr_wr_en",    32'(bus.wr_en),    32'h0);
        check("mr_rd_en",    32'(bus.rd_en),    32'h0);
        check("mr_req_addr", 32'(bus.req_addr), 32'h0);
        check("mr_wr_data",  32'(bus.wr_data),  32'h0);
        #20ns;
        rst_n = 1'b1;
        spi_bits(16'h5A00, 8, dummy);
        spi_end();
        check("mr_wr_none",   32'(wr_seen - w0), 32'd0);
        check("mr_addr_held", 32'(bus.req_addr), 32'h0);
        w0 = wr_seen;
        spi_frame(CMD_WRITE, 8'h03, 16'h1234, rx);
        check("mr_next_wr_cnt",  32'(wr_seen - w0), 32'd1);
        check("mr_next_wr_addr", 32'(last_wr_addr), 32'h03);
        check("mr_next_wr_data", 32'(last_wr_data), 32'h1234);
        spi_frame(CMD_READ, 8'h03, 16'h0000, rx);
        check("mr_readback", 32'(rx), 32'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
